psum_serializer: RTL and testbench

PSUM_SERIALIZER -- requirements
Module: psum_serializer

---
 rtl/psum_serializer_if.sv | 21 ++
 rtl/psum_serializer.sv | 104 ++++++++++
 tb/tb_psum_serializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_serializer_if.sv
// Handshake bundle between the adder-tree output register, the serializer and the lane consumer.
interface psum_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sums;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    modport master (
        output in_valid, in_sums, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );

    modport slave (
        input  in_valid, in_sums, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface

// File: rtl/psum_serializer.sv
// Buffers 4-lane INT16 sum vectors and emits them one lane per out transfer, lane 0 first.
// Define PSUM_SER_FIFO2_EN for a 2-entry buffer that streams back-to-back vectors without a bubble.
module psum_serializer (
    input  logic                clk,
    input  logic                reset,
    psum_serializer_if.slave    bus
);
    localparam int unsigned INT16  = 16;
    localparam int unsigned LENGTH = 16;
    localparam int unsigned SUMW   = (LENGTH * INT16) / 4;
`ifdef PSUM_SER_FIFO2_EN
    localparam logic [1:0]  DEPTH  = 2'd2;
`else
    localparam logic [1:0]  DEPTH  = 2'd1;
`endif

    typedef enum logic {IDLE, SEND} state_e;

    state_e            state_q, state_d;
    logic [SUMW-1:0]   head_q, head_d;
`ifdef PSUM_SER_FIFO2_EN
    logic [SUMW-1:0]   tail_q, tail_d;
`endif
    logic [1:0]        count_q, count_d;
    logic [1:0]        lane_q, lane_d;
    logic              ready_q, ready_d;
    logic [INT16-1:0]  data_q, data_d;
    logic              last_q, last_d;
    logic              in_fire, out_fire;

    // Reset gates the registered ready so no vector is accepted during the reset cycle.
    assign bus.in_ready  = ready_q & ~reset;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = data_q;
    assign bus.out_lane  = lane_q;
    assign bus.out_last  = last_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_comb begin
        head_d  = head_q;
`ifdef PSUM_SER_FIFO2_EN
        tail_d  = tail_q;
`endif
        count_d = count_q;
        lane_d  = lane_q;

        if (out_fire) begin
            lane_d = lane_q + 2'd1;
            if (last_q) begin
                count_d = count_q - 2'd1;
`ifdef PSUM_SER_FIFO2_EN
                head_d  = tail_q;
`endif
            end
        end

        // Push lands after any pop so a freed slot can be refilled on the out_last edge.
        if (in_fire) begin
`ifdef PSUM_SER_FIFO2_EN
            if (count_d == 2'd0) begin
                head_d = bus.in_sums;
            end else begin
                tail_d = bus.in_sums;
            end
`else
            head_d = bus.in_sums;
`endif
            count_d = count_d + 2'd1;
        end

        state_d = (count_d != 2'd0) ? SEND : IDLE;
        ready_d = (count_d < DEPTH);
        data_d  = (count_d != 2'd0) ? head_d[{lane_d, 4'd0} +: INT16] : '0;
        last_d  = (count_d != 2'd0) && (lane_d == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
`ifdef PSUM_SER_FIFO2_EN
            tail_q  <= '0;
`endif
            count_q <= '0;
            lane_q  <= '0;
            ready_q <= 1'b1;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
`ifdef PSUM_SER_FIFO2_EN
            tail_q  <= tail_d;
`endif
            count_q <= count_d;
            lane_q  <= lane_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_psum_serializer.sv
// Scoreboard bench for psum_serializer: expected lanes are queued on input accept and checked on output transfer.
module tb_psum_serializer;
`ifdef PSUM_SER_FIFO2_EN
    localparam int EXP_DEPTH = 2;
    localparam int EXP_GAP   = 0;
`else
    localparam int EXP_DEPTH = 1;
    localparam int EXP_GAP   = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [18:0] sb[$];

    psum_serializer_if bus();

    psum_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, then report what the coming rising edge will transfer.
    task automatic cycle(input logic vin, input logic [63:0] sums, input logic ordy,
                         output logic ov, output logic fo, output logic [18:0] obs, output logic acc);
        @(negedge clk);
        bus.in_valid  = vin;
        bus.in_sums   = sums;
        bus.out_ready = ordy;
        #1;
        ov  = bus.out_valid;
        fo  = bus.out_valid & ordy;
        obs = {bus.out_data, bus.out_lane, bus.out_last};
        acc = vin & bus.in_ready;
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                sb.push_back({sums[16*k +: 16], 2'(k), (k == 3)});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sums   = '1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); else passed++;
        total++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); else passed++;
        total++; if (bus.out_lane !== 2'd0) $display("FAIL reset_out_lane: got %0d expected 0", bus.out_lane); else passed++;
        total++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", bus.out_last); else passed++;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
    endtask

    task automatic test_single();
        logic ov, fo, acc;
        logic [18:0] obs, exp;
        int nvalid = 0;
        cycle(1'b1, 64'h0004_0003_0002_0001, 1'b1, ov, fo, obs, acc);
        total++; if (acc !== 1'b1) $display("FAIL single_accept: got %b expected 1", acc); else passed++;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, '0, 1'b1, ov, fo, obs, acc);
            if (c == 0) begin
                total++; if (ov !== 1'b1) $display("FAIL single_latency: out_valid got %b expected 1", ov); else passed++;
            end
            if (ov) nvalid++;
            if (fo) begin
                total++;
                if (sb.size() == 0) $display("FAIL single_lane: got %h expected no output", obs);
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) $display("FAIL single_lane: got %h expected %h", obs, exp); else passed++;
                end
            end
        end
        total++; if (nvalid != 4) $display("FAIL single_valid_cycles: got %0d expected 4", nvalid); else passed++;
        total++; if (ov !== 1'b0) $display("FAIL single_idle_after: out_valid got %b expected 0", ov); else passed++;
        total++; if (sb.size() != 0) $display("FAIL single_drained: %0d lanes left expected 0", sb.size()); else passed++;
    endtask

    task automatic test_backpressure();
        logic ov, fo, acc, ordy;
        logic [18:0] obs, exp, held;
        logic have_hold = 1'b0;
        cycle(1'b1, 64'h0004_0003_0002_0001, 1'b0, ov, fo, obs, acc);
        for (int c = 0; c < 30; c++) begin
            ordy = ((c % 4) == 0) || ((c % 4) == 3);
            cycle(1'b0, '0, ordy, ov, fo, obs, acc);
            if (have_hold) begin
                total++; if (obs !== held || ov !== 1'b1) $display("FAIL stall_hold: got %h valid %b expected %h valid 1", obs, ov, held); else passed++;
            end
            have_hold = ov && !ordy;
            held = obs;
            if (fo) begin
                total++;
                if (sb.size() == 0) $display("FAIL bp_lane: got %h expected no output", obs);
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) $display("FAIL bp_lane: got %h expected %h", obs, exp); else passed++;
                end
            end
        end
        total++; if (sb.size() != 0) $display("FAIL bp_drained: %0d lanes left expected 0", sb.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        logic ov, fo, acc;
        logic [18:0] obs, exp;
        logic [63:0] vecs[2];
        int idx = 0, nvalid = 0, first = -1, last = -1;
        vecs[0] = 64'h8000_7FFF_FFFF_0000;
        vecs[1] = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 30; c++) begin
            cycle(idx < 2, (idx < 2) ? vecs[idx] : 64'h0, 1'b1, ov, fo, obs, acc);
            if (acc) idx++;
            if (ov) begin
                nvalid++;
                if (first < 0) first = c;
                last = c;
            end
            if (fo) begin
                total++;
                if (sb.size() == 0) $display("FAIL b2b_lane: got %h expected no output", obs);
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) $display("FAIL b2b_lane: got %h expected %h", obs, exp); else passed++;
                end
            end
        end
        total++; if (nvalid != 8) $display("FAIL b2b_valid_cycles: got %0d expected 8", nvalid); else passed++;
        total++; if (last - first + 1 - nvalid != EXP_GAP) $display("FAIL b2b_gap: got %0d expected %0d", last - first + 1 - nvalid, EXP_GAP); else passed++;
        total++; if (sb.size() != 0) $display("FAIL b2b_drained: %0d lanes left expected 0", sb.size()); else passed++;
    endtask

    task automatic test_full();
        logic ov, fo, acc;
        logic [18:0] obs, exp;
        int nacc = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, {$urandom, $urandom}, 1'b0, ov, fo, obs, acc);
            if (acc) nacc++;
        end
        total++; if (nacc != EXP_DEPTH) $display("FAIL full_accepted: got %0d expected %0d", nacc, EXP_DEPTH); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); else passed++;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, '0, 1'b1, ov, fo, obs, acc);
            if (fo) begin
                total++;
                if (sb.size() == 0) $display("FAIL full_lane: got %h expected no output", obs);
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) $display("FAIL full_lane: got %h expected %h", obs, exp); else passed++;
                end
            end
        end
        total++; if (sb.size() != 0) $display("FAIL full_drained: %0d lanes left expected 0", sb.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        logic ov, fo, acc;
        logic [18:0] obs, exp;
        int nout = 0;
        cycle(1'b1, 64'h8000_7FFF_FFFF_0000, 1'b1, ov, fo, obs, acc);
        for (int c = 0; c < 10 && nout < 2; c++) begin
            cycle(1'b0, '0, 1'b1, ov, fo, obs, acc);
            if (fo) begin
                nout++;
                total++;
                exp = sb.pop_front();
                if (obs !== exp) $display("FAIL mid_lane: got %h expected %h", obs, exp); else passed++;
            end
        end
        total++; if (nout != 2) $display("FAIL mid_prefix: got %0d transfers expected 2", nout); else passed++;
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sums   = 64'hDEAD_BEEF_CAFE_F00D;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b expected 1", bus.in_ready); else passed++;
        sb.delete();
        nout = 0;
        cycle(1'b1, 64'h0000_0000_0000_00AA, 1'b1, ov, fo, obs, acc);
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, '0, 1'b1, ov, fo, obs, acc);
            if (fo) begin
                nout++;
                total++;
                if (sb.size() == 0) $display("FAIL mid_c_lane: got %h expected no output", obs);
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) $display("FAIL mid_c_lane: got %h expected %h", obs, exp); else passed++;
                end
            end
        end
        total++; if (nout != 4) $display("FAIL mid_c_count: got %0d transfers expected 4", nout); else passed++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sums   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end
endmodule
